rgb_fade_sequencer: RTL
=======================

// Module: rgb_fade_sequencer
// PURPOSE
//   Hue-wheel fade controller for the RGB LED PWM datapath; sits between clk and the PWM stage in top.
//   Walks six hue phases, ramps one channel's duty per phase and publishes glitch-free duty words,
//   updated only on PWM period boundaries. Optionally includes the PWM comparators (RGB_R/G/B).
// PARAMETERS
//   PWM_INTERVAL   1200   PWM period in clk cycles; also full-scale duty value
//   STEP_INTERVAL  12000  clk cycles between ramp steps (while en=1)
//   INC            10     duty increment per ramp step; 1 <= INC <= PWM_INTERVAL
//   (localparam DW = $clog2(PWM_INTERVAL+1))
// PORTS
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   en            in   1   1 = ramp advances; 0 = ramp/phase frozen
//   restart       in   1   sync pulse: return to phase 0, level 0, all counters 0
//   duty_r        out  DW  red duty, 0..PWM_INTERVAL
//   duty_g        out  DW  green duty
//   duty_b        out  DW  blue duty
//   phase         out  3   current hue phase 0..5
//   period_start  out  1   1-cycle pulse when pwm_cnt==0
//   RGB_R/G/B     out  1   active-low LED drive (RGB_PWM_OUT_EN only, else tied 1)
// BEHAVIOUR
//   Reset (async, rst_n=0): pwm_cnt=0, step_cnt=0, lvl=0, phase=0, duty_*=0, period_start=0, RGB_*=1.
//   pwm_cnt: free-runs 0..PWM_INTERVAL-1, wraps to 0; runs regardless of en.
//   period_start = registered (pwm_cnt==0); first pulse one cycle after reset release.
//   step_cnt: counts only when en=1; tick when step_cnt==STEP_INTERVAL-1 && en, then wraps to 0.
//   en=0: step_cnt, lvl, phase hold; duty_* keep last values; PWM keeps running.
//   On tick: if lvl+INC >= PWM_INTERVAL -> lvl<=0, phase<=(phase==5)?0:phase+1; else lvl<=lvl+INC.
//   Use DW+1-bit sum for the compare (no overflow wrap).
//   Target duties per phase (up=lvl, dn=PWM_INTERVAL-lvl, max=PWM_INTERVAL):
//     PH0 R=max G=up  B=0 | PH1 R=dn  G=max B=0 | PH2 R=0  G=max B=up
//     PH3 R=0  G=dn  B=max | PH4 R=up G=0  B=max | PH5 R=max G=0  B=dn
//   Shadow load: duty_* <= targets on the cycle where pwm_cnt==0 (same edge period_start rises).
//   Latency: lvl/phase change -> duty_* visible at next pwm_cnt==0 edge (<= PWM_INTERVAL cycles).
//   restart=1: pwm_cnt, step_cnt, lvl, phase <= 0 next edge; duty_* unchanged until next boundary.
//   restart beats a coincident tick; restart while en=0 still resets.
//   Phase wrap 5->0 is seamless: R is max at end of PH5 and start of PH0.
//   Illegal phase 6/7 (SEU only): next edge forces phase=0, lvl=0.
// CONFIGURATION
//   RGB_PWM_OUT_EN defined: RGB_x = ~(pwm_cnt < duty_x), registered, 1-cycle latency.
//     Duty 0 -> constant 1 (off); duty PWM_INTERVAL -> constant 0 (on).
//   Not defined: RGB_R/G/B tied 1'b1; no comparator logic; duty_* ports unchanged.
// TESTING (PWM_INTERVAL=12, STEP_INTERVAL=4, INC=3)
//   1 rst_n low mid-ramp (phase 3) -> same cycle: duty_*=0, phase=0, RGB_*=1; hold 5 cycles, no change.
//   2 en=1 from reset -> lvl=3 after 4 clks; at pwm_cnt==0 (clk 12): duty_r=12, duty_g=3, duty_b=0.
//   3 en=1 continuous -> phase 0..5 changes every 16 clks; back to 0 at clk 96; period_start every 12.
//   4 en=0 at lvl=6 for 40 clks -> lvl, phase, duty_* constant; period_start still every 12 clks.
//   5 restart same cycle as tick at lvl=9 -> lvl=0, phase unchanged at 0 (no advance), pwm_cnt=0.
//   6 RGB_PWM_OUT_EN, duty_r=12/g=3/b=0 -> RGB_R always 0, RGB_G low 3 of 12 clks, RGB_B always 1.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: six-phase hue-wheel fade with period-aligned duty shadow registers.
// Optional PWM comparators on RGB_R/G/B are built when RGB_PWM_OUT_EN is defined.
module rgb_fade_sequencer #(
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEP_INTERVAL = 12000,
    parameter int INC           = 10,
    localparam int DW = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          restart,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    phase,
    output logic          period_start,
    output logic          RGB_R,
    output logic          RGB_G,
    output logic          RGB_B
);

    localparam int SW = $clog2(STEP_INTERVAL + 1);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4,
        PH5 = 3'd5
    } phase_t;

    logic [DW-1:0] pwm_cnt;
    logic [SW-1:0] step_cnt;
    logic [DW-1:0] lvl_q;
    logic [DW-1:0] lvl_d;
    phase_t        phase_q;
    phase_t        phase_d;
    phase_t        ph_adv;
    logic          ph_ok;

    logic          pwm_zero;
    logic          pwm_wrap;
    logic          tick;
    logic [DW:0]   lvl_sum;
    logic          lvl_full;

    logic [DW-1:0] lvl_up;
    logic [DW-1:0] lvl_dn;
    logic [DW-1:0] lvl_max;
    logic [DW-1:0] tgt_r;
    logic [DW-1:0] tgt_g;
    logic [DW-1:0] tgt_b;

    assign pwm_zero = (pwm_cnt == '0);
    assign pwm_wrap = (pwm_cnt == DW'(PWM_INTERVAL - 1));
    assign tick     = en && (step_cnt == SW'(STEP_INTERVAL - 1));
    // One extra bit keeps lvl+INC from wrapping before the full-scale compare
    assign lvl_sum  = {1'b0, lvl_q} + (DW+1)'(INC);
    assign lvl_full = (lvl_sum >= (DW+1)'(PWM_INTERVAL));

    assign lvl_up  = lvl_q;
    assign lvl_dn  = DW'(PWM_INTERVAL) - lvl_q;
    assign lvl_max = DW'(PWM_INTERVAL);

    assign phase = phase_q;

    // PWM period counter, free-running independent of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (restart || pwm_wrap) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DW'(1);
        end
    end

    // Ramp step prescaler, advances only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (restart) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= '0;
        end else if (en) begin
            step_cnt <= step_cnt + SW'(1);
        end
    end

    // Phase/level state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH0;
            lvl_q   <= '0;
        end else begin
            phase_q <= phase_d;
            lvl_q   <= lvl_d;
        end
    end

    // Phase/level next state: restart wins, illegal codes recover to PH0
    always_comb begin
        phase_d = phase_q;
        lvl_d   = lvl_q;
        ph_adv  = PH0;
        ph_ok   = 1'b1;
        unique case (phase_q)
            PH0:     ph_adv = PH1;
            PH1:     ph_adv = PH2;
            PH2:     ph_adv = PH3;
            PH3:     ph_adv = PH4;
            PH4:     ph_adv = PH5;
            PH5:     ph_adv = PH0;
            default: ph_ok  = 1'b0;
        endcase
        if (restart || !ph_ok) begin
            phase_d = PH0;
            lvl_d   = '0;
        end else if (tick) begin
            if (lvl_full) begin
                phase_d = ph_adv;
                lvl_d   = '0;
            end else begin
                lvl_d   = lvl_sum[DW-1:0];
            end
        end
    end

    // Target duty words for the current phase and level
    always_comb begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
        unique case (phase_q)
            PH0: begin
                tgt_r = lvl_max;
                tgt_g = lvl_up;
            end
            PH1: begin
                tgt_r = lvl_dn;
                tgt_g = lvl_max;
            end
            PH2: begin
                tgt_g = lvl_max;
                tgt_b = lvl_up;
            end
            PH3: begin
                tgt_g = lvl_dn;
                tgt_b = lvl_max;
            end
            PH4: begin
                tgt_r = lvl_up;
                tgt_b = lvl_max;
            end
            PH5: begin
                tgt_r = lvl_max;
                tgt_b = lvl_dn;
            end
            default: begin
                tgt_r = '0;
                tgt_g = '0;
                tgt_b = '0;
            end
        endcase
    end

    // Shadow duty words, reloaded only at the period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r       <= '0;
            duty_g       <= '0;
            duty_b       <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= pwm_zero;
            if (pwm_zero) begin
                duty_r <= tgt_r;
                duty_g <= tgt_g;
                duty_b <= tgt_b;
            end
        end
    end

`ifdef RGB_PWM_OUT_EN
    // Active-low LED comparators, registered for glitch-free drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RGB_R <= 1'b1;
            RGB_G <= 1'b1;
            RGB_B <= 1'b1;
        end else begin
            RGB_R <= ~(pwm_cnt < duty_r);
            RGB_G <= ~(pwm_cnt < duty_g);
            RGB_B <= ~(pwm_cnt < duty_b);
        end
    end
`else
    assign RGB_R = 1'b1;
    assign RGB_G = 1'b1;
    assign RGB_B = 1'b1;
`endif

endmodule
